mp_loop_sequencer: RTL and testbench
====================================

Name: mp_loop_sequencer

Overview:
- Top-level scheduler for the matching-pursuit datapath.
- After one start pulse it runs the Y-to-R copy once, then iterates four stages: inner products (correlate), max identification, tolerance check, and x/residual update.
- Each sub-unit is driven by a one-cycle start strobe and answers with a done strobe.
- It counts iterations, stops on the iteration limit or on a small max correlation, and reports done/busy/k to the chip top.

Parameters:
- ITER_WIDTH, 8, width of the iteration count and k counter.
- FIXED_WIDTH, 32, width of the fixed-point correlation value (fp_32_t).
- STAGE_TIMEOUT, 4096, watchdog limit in cycles per stage wait; used only with the watchdog feature.

Ports:
- clock  in  1  system clock.
- resetN  in  1  reset: asynchronous assert, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  level; forces return to IDLE.
- num_iter  in  ITER_WIDTH  maximum iterations; latched on start.
- tol  in  FIXED_WIDTH  unsigned stop threshold; latched on start.
- max_value  in  FIXED_WIDTH  signed fixed-point max correlation from the max-identification unit.
- copy_start  out  1  Y-to-R copy strobe; copy_done  in  1  copy-complete strobe.
- corr_start  out  1  inner-product strobe; corr_done  in  1  inner-product-complete strobe.
- max_start  out  1  max-identification strobe; max_done  in  1  max-identification-complete strobe.
- upd_start  out  1  x/residual update strobe; upd_done  in  1  update-complete strobe.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle completion pulse.
- early_stop  out  1  run ended on tolerance.
- k_count  out  ITER_WIDTH  completed iterations.
- error  out  1  watchdog fired; tied 0 without the feature.

Behaviour:
- States: IDLE, COPY, CORR, MAX, CHECK, UPD, FINISH.
- Reset:
  - State goes to IDLE.
  - All outputs are 0: strobes, busy, done, early_stop, k_count, error.
  - The latched num_iter and tol are cleared.
- Start acceptance:
  - start is sampled in IDLE. If high, num_iter and tol are latched, k_count, early_stop and error are cleared, and the next state is COPY.
  - start while busy is ignored.
- Stage strobes:
  - Each stage strobe is registered and high for exactly the first cycle of its state.
  - The matching done is sampled only from the second cycle of that state onward; a done coinciding with the strobe cycle is ignored.
  - Done strobes belonging to other states are ignored.
- Latency: start high at edge N gives copy_start high in cycle N+1. Each state transition costs one clock after the qualifying done.
- Transitions:
  - COPY, on copy_done: to FINISH if latched num_iter==0, else to CORR.
  - CORR, on corr_done: to MAX.
  - MAX, on max_done: to CHECK.
  - CHECK: exactly one cycle, no strobe.
- CHECK arithmetic:
  - Compute |max_value| in FIXED_WIDTH. The most negative input saturates to 2^(FIXED_WIDTH-1)-1.
  - If |max_value| <= tol: set early_stop=1, go to FINISH.
  - Otherwise go to UPD.
  - tol=0 never stops early unless max_value==0.
- UPD, on upd_done:
  - k_count increments.
  - If the new k_count equals num_iter, go to FINISH; else go to CORR.
  - k_count saturates at all-ones and never wraps.
- FINISH:
  - done=1 for one cycle, busy still 1; next state is IDLE.
  - k_count and early_stop hold until the next accepted start.
- abort:
  - From any non-IDLE state, the next state is IDLE. All strobes drop at once, done is not pulsed, k_count holds.
  - abort has priority over a done in the same cycle.
  - abort and start together in IDLE: start is ignored.
- Reset mid-run: immediate return to IDLE with the outputs above; no done pulse.

Optional Feature:
- MP_SEQ_WATCHDOG_EN defined:
  - A per-state cycle counter clears on every state entry and counts while in COPY, CORR, MAX or UPD.
  - Reaching STAGE_TIMEOUT without the qualifying done sets error=1 (sticky until the next accepted start) and moves to FINISH; done still pulses.
- Undefined: no counter, error tied 0, stages wait indefinitely.

Decomposition:
- Shared package (verisparse header/package):
  - mp_seq_state_t enum.
  - fp_32_t.
  - Constant MP_ITER_WIDTH_DEFAULT.
  - Function vs_fixed_abs_sat (saturating absolute value).
- One natural sub-module: mp_stage_watchdog, holding the counter, clear and timeout flag; instantiated only under MP_SEQ_WATCHDOG_EN.

Test Plan:
- num_iter=3, tol=0, each done 5 cycles after its strobe, max_value=0x00010000:
  - copy_start once, then corr/max/upd strobes 3 times each; done pulses once.
  - k_count=3, early_stop=0, busy low the cycle after done.
- num_iter=10, tol=0x00008000, max_value=0x00010000 for iterations 0-1, then 0xFFFF9000 (magnitude 0x7000):
  - After 2 upd_done and 3 max_done, early_stop=1, k_count=2, no third upd_start.
- num_iter=0: copy_start, then copy_done leads to done with k_count=0; corr_start never asserts.
- Robustness:
  - abort asserted 2 cycles after the second corr_start leads to IDLE next cycle, no done, k_count=1.
  - Later, start mid-run is ignored.
  - corr_done asserted in the strobe cycle is ignored.
- Reset and saturation:
  - resetN pulled low mid-UPD: all outputs are 0 asynchronously.
  - max_value=0x80000000 with tol=0x7FFFFFFF leads to early_stop=1.
- With MP_SEQ_WATCHDOG_EN and STAGE_TIMEOUT=16, max_done withheld: error=1 and done pulse after 16 cycles in MAX.

Source files
------------

// File: rtl/mp_loop_sequencer_pkg.sv
// Shared types and helpers for the matching-pursuit loop sequencer.
package mp_loop_sequencer_pkg;

    localparam int MP_ITER_WIDTH_DEFAULT = 8;

    typedef logic signed [31:0] fp_32_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COPY   = 3'd1,
        ST_CORR   = 3'd2,
        ST_MAX    = 3'd3,
        ST_CHECK  = 3'd4,
        ST_UPD    = 3'd5,
        ST_FINISH = 3'd6
    } mp_seq_state_t;

    // |value| with the most negative code clamped to the largest positive code.
    function automatic logic [31:0] vs_fixed_abs_sat(input fp_32_t value);
        logic [31:0] mag;
        if (value == 32'sh8000_0000) begin
            mag = 32'h7FFF_FFFF;
        end else if (value[31]) begin
            mag = 32'(~value) + 32'd1;
        end else begin
            mag = 32'(value);
        end
        return mag;
    endfunction

endpackage

// File: rtl/mp_loop_sequencer_if.sv
// Stage start/done handshakes and the max-correlation value shared with the datapath.
interface mp_loop_sequencer_if #(
    parameter int FIXED_WIDTH = 32
);
    logic                          copy_start;
    logic                          copy_done;
    logic                          corr_start;
    logic                          corr_done;
    logic                          max_start;
    logic                          max_done;
    logic                          upd_start;
    logic                          upd_done;
    logic signed [FIXED_WIDTH-1:0] max_value;

    modport master (
        output copy_start, corr_start, max_start, upd_start,
        input  copy_done, corr_done, max_done, upd_done, max_value
    );

    modport slave (
        input  copy_start, corr_start, max_start, upd_start,
        output copy_done, corr_done, max_done, upd_done, max_value
    );
endinterface

// File: rtl/mp_loop_sequencer_watchdog.sv
// Per-stage cycle watchdog (module mp_stage_watchdog), used when MP_SEQ_WATCHDOG_EN is defined.
module mp_stage_watchdog #(
    parameter int STAGE_TIMEOUT = 4096
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);
    localparam int CW = $clog2(STAGE_TIMEOUT + 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter, zeroed on every state entry.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (count_en && !timeout) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Fires during the STAGE_TIMEOUT-th cycle spent waiting in the stage.
    assign timeout = count_en && (cnt_r == CW'(STAGE_TIMEOUT - 1));
endmodule

// File: rtl/mp_loop_sequencer.sv
// Matching-pursuit loop scheduler: copy once, then correlate/max/check/update until done.
// Optional per-stage watchdog enabled by defining MP_SEQ_WATCHDOG_EN.
module mp_loop_sequencer
    import mp_loop_sequencer_pkg::*;
#(
    parameter int ITER_WIDTH    = MP_ITER_WIDTH_DEFAULT,
    parameter int FIXED_WIDTH   = 32,
    parameter int STAGE_TIMEOUT = 4096
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ITER_WIDTH-1:0]  num_iter,
    input  logic [FIXED_WIDTH-1:0] tol,
    mp_loop_sequencer_if.master    stg,
    output logic                   busy,
    output logic                   done,
    output logic                   early_stop,
    output logic [ITER_WIDTH-1:0]  k_count,
    output logic                   error
);
    mp_seq_state_t          state_r, next_s;
    logic [ITER_WIDTH-1:0]  num_iter_r, k_r, k_inc_s;
    logic [FIXED_WIDTH-1:0] tol_r, abs_s;
    logic copy_start_r, corr_start_r, max_start_r, upd_start_r;
    logic busy_r, done_r, early_r, error_r;
    logic stage_first_s, k_inc_en_s, early_set_s, error_set_s, wd_timeout_s, accept_s;

    // A stage strobe is high only in the first cycle of its state, when its done is not yet trusted.
    assign stage_first_s = copy_start_r | corr_start_r | max_start_r | upd_start_r;
    assign abs_s         = FIXED_WIDTH'(vs_fixed_abs_sat(fp_32_t'(stg.max_value)));
    assign k_inc_s       = (k_r == {ITER_WIDTH{1'b1}}) ? k_r : k_r + ITER_WIDTH'(1);
    assign accept_s      = (state_r == ST_IDLE) && (next_s == ST_COPY);

`ifdef MP_SEQ_WATCHDOG_EN
    mp_stage_watchdog #(.STAGE_TIMEOUT(STAGE_TIMEOUT)) u_watchdog (
        .clock    (clock),
        .resetN   (resetN),
        .clear    (next_s != state_r),
        .count_en (state_r inside {ST_COPY, ST_CORR, ST_MAX, ST_UPD}),
        .timeout  (wd_timeout_s)
    );
`else
    assign wd_timeout_s = 1'b0;
`endif

    // Next-state and per-cycle event decode; abort overrides any stage completion.
    always_comb begin
        next_s      = state_r;
        k_inc_en_s  = 1'b0;
        early_set_s = 1'b0;
        error_set_s = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) next_s = ST_COPY;
                    else                 next_s = ST_IDLE;
                end
                ST_COPY: begin
                    if (stg.copy_done && !stage_first_s) begin
                        if (num_iter_r == '0) next_s = ST_FINISH;
                        else                  next_s = ST_CORR;
                    end else if (wd_timeout_s) begin
                        next_s      = ST_FINISH;
                        error_set_s = 1'b1;
                    end else begin
                        next_s = ST_COPY;
                    end
                end
                ST_CORR: begin
                    if (stg.corr_done && !stage_first_s) begin
                        next_s = ST_MAX;
                    end else if (wd_timeout_s) begin
                        next_s      = ST_FINISH;
                        error_set_s = 1'b1;
                    end else begin
                        next_s = ST_CORR;
                    end
                end
                ST_MAX: begin
                    if (stg.max_done && !stage_first_s) begin
                        next_s = ST_CHECK;
                    end else if (wd_timeout_s) begin
                        next_s      = ST_FINISH;
                        error_set_s = 1'b1;
                    end else begin
                        next_s = ST_MAX;
                    end
                end
                ST_CHECK: begin
                    if (abs_s <= tol_r) begin
                        next_s      = ST_FINISH;
                        early_set_s = 1'b1;
                    end else begin
                        next_s = ST_UPD;
                    end
                end
                ST_UPD: begin
                    if (stg.upd_done && !stage_first_s) begin
                        k_inc_en_s = 1'b1;
                        if (k_inc_s == num_iter_r) next_s = ST_FINISH;
                        else                       next_s = ST_CORR;
                    end else if (wd_timeout_s) begin
                        next_s      = ST_FINISH;
                        error_set_s = 1'b1;
                    end else begin
                        next_s = ST_UPD;
                    end
                end
                ST_FINISH: next_s = ST_IDLE;
                default:   next_s = ST_IDLE;
            endcase
        end
    end

    // State register and registered strobes/status derived from the upcoming state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r      <= ST_IDLE;
            copy_start_r <= 1'b0;
            corr_start_r <= 1'b0;
            max_start_r  <= 1'b0;
            upd_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= next_s;
            copy_start_r <= (next_s == ST_COPY) && (state_r != ST_COPY);
            corr_start_r <= (next_s == ST_CORR) && (state_r != ST_CORR);
            max_start_r  <= (next_s == ST_MAX)  && (state_r != ST_MAX);
            upd_start_r  <= (next_s == ST_UPD)  && (state_r != ST_UPD);
            busy_r       <= (next_s != ST_IDLE);
            done_r       <= (next_s == ST_FINISH);
        end
    end

    // Run configuration and result registers; results persist until the next accepted start.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            num_iter_r <= '0;
            tol_r      <= '0;
            k_r        <= '0;
            early_r    <= 1'b0;
            error_r    <= 1'b0;
        end else if (accept_s) begin
            num_iter_r <= num_iter;
            tol_r      <= tol;
            k_r        <= '0;
            early_r    <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (k_inc_en_s)  k_r     <= k_inc_s;
            if (early_set_s) early_r <= 1'b1;
            if (error_set_s) error_r <= 1'b1;
        end
    end

    assign stg.copy_start = copy_start_r;
    assign stg.corr_start = corr_start_r;
    assign stg.max_start  = max_start_r;
    assign stg.upd_start  = upd_start_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign early_stop     = early_r;
    assign k_count        = k_r;
    assign error          = error_r;
endmodule

// File: tb/tb_mp_loop_sequencer.sv
// Directed bench for mp_loop_sequencer: run-level vector table plus hand-timed corner sequences.
module tb_mp_loop_sequencer;
    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_iter = 8'd0;
    logic [31:0] tol = 32'd0;
    logic        busy, done, early_stop, error;
    logic [7:0]  k_count;

    mp_loop_sequencer_if #(.FIXED_WIDTH(32)) stg();

    logic        resp_en = 1'b1;
    logic        rsp_copy = 1'b0, rsp_corr = 1'b0, rsp_max = 1'b0, rsp_upd = 1'b0;
    logic        man_copy = 1'b0, man_corr = 1'b0, man_max = 1'b0, man_upd = 1'b0;
    logic [31:0] rsp_mv = 32'd0, man_mv = 32'd0;

    assign stg.copy_done = resp_en ? rsp_copy : man_copy;
    assign stg.corr_done = resp_en ? rsp_corr : man_corr;
    assign stg.max_done  = resp_en ? rsp_max  : man_max;
    assign stg.upd_done  = resp_en ? rsp_upd  : man_upd;
    assign stg.max_value = resp_en ? rsp_mv   : man_mv;

    mp_loop_sequencer #(.ITER_WIDTH(8), .FIXED_WIDTH(32), .STAGE_TIMEOUT(16)) dut (
        .clock(clock), .resetN(resetN), .start(start), .abort(abort),
        .num_iter(num_iter), .tol(tol), .stg(stg.master),
        .busy(busy), .done(done), .early_stop(early_stop), .k_count(k_count), .error(error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_copy = 0, n_corr = 0, n_max = 0, n_upd = 0, n_done = 0, n_maxd = 0;
    int base_maxd = 0;
    logic [31:0] cur_mv_a = 32'd0, cur_mv_b = 32'd0;
    int cur_sw = 0;
    int cd [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Datapath model: answers each strobe with its done 5 cycles later and counts strobes.
    initial begin
        for (int s = 0; s < 4; s++) cd[s] = 0;
        forever begin
            @(negedge clock);
            rsp_copy = 1'b0; rsp_corr = 1'b0; rsp_max = 1'b0; rsp_upd = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (cd[s] > 0) begin
                    cd[s]--;
                    if (cd[s] == 0) begin
                        case (s)
                            0: rsp_copy = 1'b1;
                            1: rsp_corr = 1'b1;
                            2: begin
                                rsp_max = 1'b1;
                                rsp_mv  = ((n_maxd - base_maxd) < cur_sw) ? cur_mv_a : cur_mv_b;
                                n_maxd++;
                            end
                            default: rsp_upd = 1'b1;
                        endcase
                    end
                end
            end
            if (stg.copy_start) begin n_copy++; cd[0] = 5; end
            if (stg.corr_start) begin n_corr++; cd[1] = 5; end
            if (stg.max_start)  begin n_max++;  cd[2] = 5; end
            if (stg.upd_start)  begin n_upd++;  cd[3] = 5; end
            if (done) n_done++;
        end
    end

    task automatic launch(input logic [7:0] ni, input logic [31:0] tl,
                          input logic [31:0] mva, input logic [31:0] mvb, input int sw);
        repeat (8) @(negedge clock);
        cur_mv_a = mva; cur_mv_b = mvb; cur_sw = sw; base_maxd = n_maxd;
        num_iter = ni; tol = tl; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("copy_start_latency", {63'd0, stg.copy_start}, 64'd1);
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (done) ok = 1'b1;
            else @(negedge clock);
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no done, expected done pulse", name);
        end
    endtask

    typedef struct {
        logic [7:0]  ni;
        logic [31:0] tl, mva, mvb;
        int          sw;
        logic [7:0]  k;
        logic        early;
        int          copies, corrs, maxes, upds;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        bit ok;
        int seen, b_copy, b_corr, b_max, b_upd, b_done;
        string nm;

        vecs[0] = '{8'd3,  32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 99, 8'd3, 1'b0, 1, 3, 3, 3};
        vecs[1] = '{8'd10, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_9000, 2,  8'd2, 1'b1, 1, 3, 3, 2};
        vecs[2] = '{8'd0,  32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 99, 8'd0, 1'b0, 1, 0, 0, 0};
        vecs[3] = '{8'd5,  32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 99, 8'd0, 1'b1, 1, 1, 1, 0};
        vecs[4] = '{8'd4,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 99, 8'd0, 1'b1, 1, 1, 1, 0};
        vecs[5] = '{8'd2,  32'h0000_0FFF, 32'hFFFF_F000, 32'hFFFF_F000, 99, 8'd2, 1'b0, 1, 2, 2, 2};

        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_strobes", {60'd0, stg.copy_start, stg.corr_start, stg.max_start, stg.upd_start}, 64'd0);
        check("reset_done_early_err", {61'd0, done, early_stop, error}, 64'd0);
        check("reset_k", {56'd0, k_count}, 64'd0);
        resetN = 1'b1;

        for (int v = 0; v < 6; v++) begin
            b_copy = n_copy; b_corr = n_corr; b_max = n_max; b_upd = n_upd; b_done = n_done;
            launch(vecs[v].ni, vecs[v].tl, vecs[v].mva, vecs[v].mvb, vecs[v].sw);
            nm = $sformatf("vec%0d", v);
            wait_done(nm, ok);
            if (ok) begin
                check({nm, "_k"}, {56'd0, k_count}, {56'd0, vecs[v].k});
                check({nm, "_early"}, {63'd0, early_stop}, {63'd0, vecs[v].early});
                check({nm, "_busy_at_done"}, {62'd0, busy, error}, 64'd2);
                @(negedge clock);
                check({nm, "_idle_after"}, {62'd0, busy, done}, 64'd0);
            end
            repeat (10) @(negedge clock);
            check({nm, "_copies"}, 64'(n_copy - b_copy), 64'(vecs[v].copies));
            check({nm, "_corrs"},  64'(n_corr - b_corr), 64'(vecs[v].corrs));
            check({nm, "_maxes"},  64'(n_max - b_max),   64'(vecs[v].maxes));
            check({nm, "_upds"},   64'(n_upd - b_upd),   64'(vecs[v].upds));
            check({nm, "_dones"},  64'(n_done - b_done), 64'd1);
            check({nm, "_k_hold"}, {56'd0, k_count}, {56'd0, vecs[v].k});
        end

        // Abort two cycles after the second correlate strobe.
        b_done = n_done;
        launch(8'd10, 32'd0, 32'h0001_0000, 32'h0001_0000, 99);
        seen = 0;
        for (int i = 0; i < 500 && seen < 2; i++) begin
            @(negedge clock);
            if (stg.corr_start) seen++;
        end
        check("abort_reached_corr2", 64'(seen), 64'd2);
        repeat (2) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle", {62'd0, busy, stg.corr_start}, 64'd0);
        check("abort_k_hold", {56'd0, k_count}, 64'd1);
        repeat (12) @(negedge clock);
        check("abort_no_done", 64'(n_done - b_done), 64'd0);
        check("abort_still_idle", {63'd0, busy}, 64'd0);

        // Start mid-run is ignored.
        b_copy = n_copy;
        launch(8'd3, 32'd0, 32'h0001_0000, 32'h0001_0000, 99);
        seen = 0;
        for (int i = 0; i < 500 && seen < 2; i++) begin
            @(negedge clock);
            if (stg.corr_start) seen++;
        end
        num_iter = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("midstart", ok);
        if (ok) check("midstart_k", {56'd0, k_count}, 64'd3);
        repeat (10) @(negedge clock);
        check("midstart_one_copy", 64'(n_copy - b_copy), 64'd1);

        // Manually timed handshakes: dones coinciding with strobe cycles are ignored.
        resp_en = 1'b0; man_mv = 32'h0001_0000;
        launch(8'd1, 32'd0, 32'd0, 32'd0, 99);
        man_copy = 1'b1;
        @(negedge clock);
        man_copy = 1'b0;
        check("copy_done_in_strobe_ignored", {63'd0, stg.corr_start}, 64'd0);
        man_copy = 1'b1;
        @(negedge clock);
        man_copy = 1'b0;
        check("corr_start_after_copy_done", {63'd0, stg.corr_start}, 64'd1);
        man_corr = 1'b1;
        @(negedge clock);
        man_corr = 1'b0;
        check("corr_strobe_one_cycle", {63'd0, stg.corr_start}, 64'd0);
        repeat (2) @(negedge clock);
        check("corr_done_in_strobe_ignored", {62'd0, stg.max_start, busy}, 64'd1);
        man_corr = 1'b1;
        @(negedge clock);
        man_corr = 1'b0;
        check("max_start_after_corr_done", {63'd0, stg.max_start}, 64'd1);
        @(negedge clock);
        man_max = 1'b1;
        @(negedge clock);
        man_max = 1'b0;
        check("check_state_no_strobe", {62'd0, stg.upd_start, stg.max_start}, 64'd0);
        @(negedge clock);
        check("upd_start_after_check", {63'd0, stg.upd_start}, 64'd1);
        @(negedge clock);
        man_upd = 1'b1;
        @(negedge clock);
        man_upd = 1'b0;
        check("manual_done_pulse", {62'd0, done, busy}, 64'd3);
        check("manual_k", {56'd0, k_count}, 64'd1);
        @(negedge clock);
        check("manual_idle_after", {63'd0, busy}, 64'd0);

`ifdef MP_SEQ_WATCHDOG_EN
        // Withheld max_done: watchdog ends the run after 16 cycles in MAX.
        launch(8'd2, 32'd0, 32'd0, 32'd0, 99);
        @(negedge clock);
        man_copy = 1'b1;
        @(negedge clock);
        man_copy = 1'b0;
        @(negedge clock);
        man_corr = 1'b1;
        @(negedge clock);
        man_corr = 1'b0;
        check("wd_max_start", {63'd0, stg.max_start}, 64'd1);
        seen = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            seen++;
        end
        check("wd_cycles_in_max", 64'(seen), 64'd16);
        check("wd_error_done", {62'd0, error, done}, 64'd3);
`endif
        resp_en = 1'b1;

        // Asynchronous reset in the middle of the second update.
        b_done = n_done;
        launch(8'd5, 32'd0, 32'h0001_0000, 32'h0001_0000, 99);
        seen = 0;
        for (int i = 0; i < 500 && seen < 2; i++) begin
            @(negedge clock);
            if (stg.upd_start) seen++;
        end
        @(negedge clock);
        check("pre_reset_busy_k", {55'd0, busy, k_count}, {55'd0, 1'b1, 8'd1});
        resetN = 1'b0;
        #1;
        check("async_reset_status", {60'd0, busy, done, early_stop, error}, 64'd0);
        check("async_reset_strobes", {60'd0, stg.copy_start, stg.corr_start, stg.max_start, stg.upd_start}, 64'd0);
        check("async_reset_k", {56'd0, k_count}, 64'd0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (10) @(negedge clock);
        check("reset_no_done", 64'(n_done - b_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule
